// File: rtl/bus_deser_pkg.sv
// Shared types and default sizing for the bit-stream deserializer.
package bus_deser_pkg;

  localparam int unsigned DefaultWidth = 32;
  localparam int unsigned DefaultDropW = 8;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } state_e;

endpackage

// File: rtl/bus_deserializer_if.sv
// Bit-in / word-out handshake bundle of the deserializer.
interface bus_deserializer_if #(
  parameter int unsigned WIDTH = 32
) ();

  logic             bit_i;
  logic             bit_valid_i;
  logic             bit_ready_o;
  logic [WIDTH-1:0] word_o;
  logic             word_valid_o;
  logic             word_ready_i;

  // The deserializer itself.
  modport slave (
    input  bit_i,
    input  bit_valid_i,
    input  word_ready_i,
    output bit_ready_o,
    output word_o,
    output word_valid_o
  );

  // Stream source and word consumer.
  modport master (
    output bit_i,
    output bit_valid_i,
    output word_ready_i,
    input  bit_ready_o,
    input  word_o,
    input  word_valid_o
  );

endinterface

// File: rtl/bus_deserializer.sv
// Packs a serial bit stream LSB-first into WIDTH-bit words with one word of
// back-pressure buffering; sync_i discards a partial word and counts it.
module bus_deserializer
  import bus_deser_pkg::*;
#(
  parameter int unsigned WIDTH  = DefaultWidth,
  parameter int unsigned CNT_W  = $clog2(WIDTH),
  parameter int unsigned DROP_W = DefaultDropW
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_i,
  bus_deserializer_if.slave bus,
  output logic [DROP_W-1:0] drop_cnt_o,
  output logic              busy_o
);

  state_e              r_state, w_state_next;
  logic [CNT_W-1:0]    r_cnt, w_cnt_next;
  logic [WIDTH-1:0]    r_shreg, w_shreg_next;
  logic [WIDTH-1:0]    r_word, w_word_next;
  logic                r_word_valid, w_word_valid_next;
  logic [DROP_W-1:0]   r_drop, w_drop_next;

  logic                w_accept;
  logic                w_last;
  logic                w_slot_free;
  logic                w_drop;
  logic [WIDTH-1:0]    w_shreg_ins;

  assign w_accept    = bus.bit_valid_i && (r_state == COLLECT);
  assign w_last      = w_accept && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_slot_free = !r_word_valid || bus.word_ready_i;
  // A completing word is never partial, so sync on the last bit is a no-op.
  assign w_drop      = sync_i && (r_state == COLLECT) && (r_cnt != '0) && !w_last;

  always_comb begin
    w_state_next      = r_state;
    w_cnt_next        = r_cnt;
    w_shreg_next      = r_shreg;
    w_word_next       = r_word;
    w_word_valid_next = r_word_valid;
    w_drop_next       = r_drop;

    w_shreg_ins        = r_shreg;
    w_shreg_ins[r_cnt] = bus.bit_i;

    if (r_word_valid && bus.word_ready_i) begin
      w_word_valid_next = 1'b0;
    end

    unique case (r_state)
      COLLECT: begin
        if (w_drop) begin
          if (r_drop != '1) begin
            w_drop_next = r_drop + DROP_W'(1);
          end
          w_cnt_next = '0;
          if (w_accept) begin
            w_shreg_next[0] = bus.bit_i;
            w_cnt_next      = CNT_W'(1);
          end
        end else if (w_accept) begin
          if (w_last) begin
            w_cnt_next = '0;
            if (w_slot_free) begin
              w_word_next       = w_shreg_ins;
              w_word_valid_next = 1'b1;
            end else begin
              w_shreg_next = w_shreg_ins;
              w_state_next = FULL;
            end
          end else begin
            w_shreg_next = w_shreg_ins;
            w_cnt_next   = r_cnt + CNT_W'(1);
          end
        end
      end
      FULL: begin
        if (r_word_valid && bus.word_ready_i) begin
          w_word_next       = r_shreg;
          w_word_valid_next = 1'b1;
          w_state_next      = COLLECT;
        end
      end
      default: w_state_next = COLLECT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= COLLECT;
      r_cnt        <= '0;
      r_shreg      <= '0;
      r_word       <= '0;
      r_word_valid <= 1'b0;
      r_drop       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_cnt        <= w_cnt_next;
      r_shreg      <= w_shreg_next;
      r_word       <= w_word_next;
      r_word_valid <= w_word_valid_next;
      r_drop       <= w_drop_next;
    end
  end

  assign bus.bit_ready_o  = (r_state == COLLECT);
  assign bus.word_o       = r_word;
  assign bus.word_valid_o = r_word_valid;
  assign drop_cnt_o       = r_drop;
  assign busy_o           = (r_cnt != '0) || (r_state == FULL);

endmodule

// File: tb/tb_bus_deserializer.sv
// Directed self-checking bench for bus_deserializer (WIDTH 32, DROP_W 8).
module tb_bus_deserializer;

  logic       clk;
  logic       rst_n;
  logic       sync_i;
  logic [7:0] drop_cnt_o;
  logic       busy_o;

  int n_cmp;
  int n_err;

  bus_deserializer_if #(.WIDTH(32)) bus ();

  bus_deserializer #(
    .WIDTH (32),
    .CNT_W (5),
    .DROP_W(8)
  ) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sync_i    (sync_i),
    .bus       (bus.slave),
    .drop_cnt_o(drop_cnt_o),
    .busy_o    (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive n bits of w LSB-first on consecutive cycles; sync_i pulses with bit sync_at.
  task automatic send_bits(input logic [63:0] w, input int n, input int sync_at);
    for (int i = 0; i < n; i++) begin
      bus.bit_i       = w[i];
      bus.bit_valid_i = 1'b1;
      sync_i          = (i == sync_at);
      tick();
    end
    bus.bit_valid_i = 1'b0;
    bus.bit_i       = 1'b0;
    sync_i          = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".word"},  64'(bus.word_o), 64'h0);
    check({tag, ".valid"}, 64'(bus.word_valid_o), 64'h0);
    check({tag, ".drop"},  64'(drop_cnt_o), 64'h0);
    check({tag, ".busy"},  64'(busy_o), 64'h0);
    check({tag, ".ready"}, 64'(bus.bit_ready_o), 64'h1);
  endtask

  // Fill both the output slot and the shift register with word ready held low.
  task automatic fill_two(input logic [31:0] a, input logic [31:0] b, output int n);
    logic [63:0] ab;
    ab = {b, a};
    n  = 0;
    bus.word_ready_i = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (!bus.bit_ready_o) break;
      bus.bit_i       = ab[n % 64];
      bus.bit_valid_i = 1'b1;
      tick();
      n++;
    end
    bus.bit_valid_i = 1'b0;
  endtask

  initial begin
    int          n;
    int          ready_low;
    logic [63:0] pair;

    n_cmp            = 0;
    n_err            = 0;
    rst_n            = 1'b0;
    sync_i           = 1'b0;
    bus.bit_i        = 1'b0;
    bus.bit_valid_i  = 1'b0;
    bus.word_ready_i = 1'b1;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single word, latency.
    send_bits(64'hA5A5_1234, 31, -1);
    check("w1.valid_before_last", 64'(bus.word_valid_o), 64'h0);
    check("w1.busy_mid", 64'(busy_o), 64'h1);
    send_bits(64'h1, 1, -1);
    check("w1.valid", 64'(bus.word_valid_o), 64'h1);
    check("w1.word", 64'(bus.word_o), 64'hA5A5_1234);
    check("w1.drop", 64'(drop_cnt_o), 64'h0);
    tick();
    check("w1.valid_pulse", 64'(bus.word_valid_o), 64'h0);

    // Back-to-back words, no ready gap.
    pair      = {32'h8000_0000, 32'h0000_0001};
    ready_low = 0;
    for (int i = 0; i < 64; i++) begin
      if (!bus.bit_ready_o) ready_low++;
      bus.bit_i       = pair[i];
      bus.bit_valid_i = 1'b1;
      tick();
      if (i == 31) begin
        check("b2b.word0", 64'(bus.word_o), 64'h1);
        check("b2b.valid0", 64'(bus.word_valid_o), 64'h1);
      end
    end
    bus.bit_valid_i = 1'b0;
    check("b2b.word1", 64'(bus.word_o), 64'h8000_0000);
    check("b2b.valid1", 64'(bus.word_valid_o), 64'h1);
    check("b2b.ready_gaps", 64'(ready_low), 64'h0);
    tick();

    // Back-pressure: exactly 64 bits accepted.
    fill_two(32'h1111_2222, 32'h3333_4444, n);
    check("bp.accepted", 64'(n), 64'd64);
    check("bp.word_held", 64'(bus.word_o), 64'h1111_2222);
    check("bp.busy", 64'(busy_o), 64'h1);
    bus.word_ready_i = 1'b1;
    tick();
    bus.word_ready_i = 1'b0;
    check("bp.word2", 64'(bus.word_o), 64'h3333_4444);
    check("bp.valid2", 64'(bus.word_valid_o), 64'h1);
    check("bp.ready_back", 64'(bus.bit_ready_o), 64'h1);
    bus.word_ready_i = 1'b1;
    tick();
    check("bp.drained", 64'(bus.word_valid_o), 64'h0);
    check("bp.idle", 64'(busy_o), 64'h0);

    // Sync discards a partial word.
    send_bits(64'h1F, 5, -1);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    send_bits(64'hDEAD_BEEF, 32, -1);
    check("sync.word", 64'(bus.word_o), 64'hDEAD_BEEF);
    check("sync.drop1", 64'(drop_cnt_o), 64'h1);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    check("sync.cnt0_nodrop", 64'(drop_cnt_o), 64'h1);
    // Sync together with a bit: that bit starts the new word.
    send_bits(64'h7, 3, -1);
    send_bits(64'hCAFE_F00D, 32, 0);
    check("sync.with_bit_word", 64'(bus.word_o), 64'hCAFE_F00D);
    check("sync.with_bit_drop", 64'(drop_cnt_o), 64'h2);
    // Sync on the last bit completes the word.
    send_bits(64'h55AA_55AA, 32, 31);
    check("sync.last_word", 64'(bus.word_o), 64'h55AA_55AA);
    check("sync.last_drop", 64'(drop_cnt_o), 64'h2);
    tick();

    // Saturation.
    for (int i = 0; i < 300; i++) begin
      send_bits(64'h1, 1, -1);
      sync_i = 1'b1;
      tick();
      sync_i = 1'b0;
    end
    check("sat.drop", 64'(drop_cnt_o), 64'd255);

    // Sync while FULL is ignored.
    fill_two(32'hAAAA_0001, 32'hBBBB_0002, n);
    check("full.ready", 64'(bus.bit_ready_o), 64'h0);
    sync_i = 1'b1;
    tick();
    sync_i = 1'b0;
    check("full.drop", 64'(drop_cnt_o), 64'd255);
    check("full.word_a", 64'(bus.word_o), 64'hAAAA_0001);
    bus.word_ready_i = 1'b1;
    tick();
    check("full.word_b", 64'(bus.word_o), 64'hBBBB_0002);
    check("full.valid_b", 64'(bus.word_valid_o), 64'h1);
    tick();
    check("full.drained", 64'(bus.word_valid_o), 64'h0);

    // Asynchronous reset mid-word.
    send_bits(64'h3FF, 10, -1);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_mid");
    tick();
    rst_n = 1'b1;
    send_bits(64'h0BAD_F00D, 32, -1);
    check("rst_mid.next_word", 64'(bus.word_o), 64'h0BAD_F00D);
    check("rst_mid.next_valid", 64'(bus.word_valid_o), 64'h1);
    tick();

    // Asynchronous reset while FULL.
    fill_two(32'h0F0F_0F0F, 32'hF0F0_F0F0, n);
    check("rst_full.was_full", 64'(bus.bit_ready_o), 64'h0);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("rst_full");
    tick();
    rst_n            = 1'b1;
    bus.word_ready_i = 1'b1;
    send_bits(64'h1234_5678, 32, -1);
    check("rst_full.next_word", 64'(bus.word_o), 64'h1234_5678);
    check("rst_full.next_valid", 64'(bus.word_valid_o), 64'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
